// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams operand pairs into a registered MAC datapath and returns bias + sum(a*b)
module mac_dot_sequencer #(
    parameter int LEN_W = 16,
    parameter logic [1:0] MODE_SUM = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [47:0]      bias,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [26:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [1:0]       dsp_mode,
    output logic [26:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_x,
    output logic             dsp_cin,
    input  logic [47:0]      dsp_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      out_data
);
    localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, STREAM = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
    logic [2:0] state;
    logic [LEN_W-1:0] cnt;
    logic dcnt;
    logic [47:0] bias_r;
    logic xfer;
    assign in_ready = state == STREAM;
    assign xfer = in_valid && in_ready;
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    assign dsp_mode = MODE_SUM;
    assign dsp_cin = 1'b0;
    // idle operands are zero so bubbles add nothing; x feeds S back except when seeding bias
    assign dsp_a = xfer ? in_a : '0;
    assign dsp_b = xfer ? in_b : '0;
    assign dsp_x = state == INIT ? bias_r : dsp_s;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            dcnt <= 1'b0;
            bias_r <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt <= len;
                    bias_r <= bias;
                    state <= INIT;
                end
                INIT: begin
                    dcnt <= 1'b0;
                    state <= cnt != '0 ? STREAM : DRAIN;
                end
                STREAM: if (xfer) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == LEN_W'(1)) state <= DRAIN;
                end
                // two cycles lets the last product reach S_reg
                DRAIN: begin
                    dcnt <= ~dcnt;
                    if (dcnt) begin
                        out_data <= dsp_s;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: scoreboard bench with a two-stage MAC datapath model
module tb_mac_dot_sequencer;
    logic clk = 0, reset = 0, start = 0, in_valid = 0, out_ready = 1;
    logic [15:0] len = 0;
    logic [47:0] bias = 0;
    logic [26:0] in_a = 0;
    logic [17:0] in_b = 0;
    logic busy, in_ready, dsp_cin, out_valid;
    logic [1:0] dsp_mode;
    logic [26:0] dsp_a;
    logic [17:0] dsp_b;
    logic [47:0] dsp_x, out_data;
    logic signed [47:0] p_reg = 0;
    logic [47:0] dsp_s = 0;
    int cyc = 0, total = 0, bad = 0;
    logic [47:0] exp_q[$];
    int pa[$], pb[$];
    bit saw_ready = 0;

    mac_dot_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .bias(bias), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_mode(dsp_mode), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_x(dsp_x), .dsp_cin(dsp_cin),
        .dsp_s(dsp_s), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // product registered in cycle k+1, summed with that cycle's x into S at k+2
    always @(posedge clk) begin
        p_reg <= $signed(dsp_a) * $signed(dsp_b);
        dsp_s <= p_reg + dsp_x + {47'b0, dsp_cin};
    end

    always @(negedge clk) if (in_ready) saw_ready = 1;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got out_data=%0h with nothing expected", out_data);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL result: out_data=%0h expected %0h", out_data, e);
                end
            end
        end
    end

    task automatic run_dot(input int n, input logic [47:0] b, input int gap, output int s_cyc, output int v_cyc);
        logic [47:0] e;
        int w;
        e = b;
        for (int i = 0; i < n; i++) e = e + 48'(longint'(pa[i]) * longint'(pb[i]));
        @(posedge clk); #1;
        start = 1; len = 16'(n); bias = b; s_cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) for (int g = 0; g < gap; g++) begin
                in_valid = 0; in_a = 27'h5a5a5; in_b = 18'h3c3c;
                @(negedge clk);
                total++;
                if (dsp_a !== 27'd0 || dsp_b !== 18'd0) begin
                    bad++;
                    $display("FAIL gap_zero: dsp_a=%0h dsp_b=%0h expected 0", dsp_a, dsp_b);
                end
                @(posedge clk); #1;
            end
            in_valid = 1; in_a = 27'(pa[i]); in_b = 18'(pb[i]);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 20) begin @(negedge clk); w++; end
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL xfer_timeout: in_ready=%b expected 1", in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 30) begin @(negedge clk); w++; end
        if (!out_valid) begin
            total++; bad++; v_cyc = -1;
            $display("FAIL valid_timeout: out_valid=%b expected 1", out_valid);
        end else v_cyc = cyc;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        total += 8;
        if (busy !== 0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (in_ready !== 0) begin bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        if (out_valid !== 0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (out_data !== 48'd0) begin bad++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
        if (dsp_a !== 27'd0 || dsp_b !== 18'd0) begin bad++; $display("FAIL rst_dsp_ab: got %0h/%0h expected 0", dsp_a, dsp_b); end
        if (dsp_mode !== 2'b00) begin bad++; $display("FAIL rst_mode: got %b expected 00", dsp_mode); end
        if (dsp_cin !== 0) begin bad++; $display("FAIL rst_cin: got %b expected 0", dsp_cin); end
        if (dsp_x !== dsp_s) begin bad++; $display("FAIL rst_x_hold: dsp_x=%0h expected %0h", dsp_x, dsp_s); end
    endtask

    task automatic test_basic();
        int s, v;
        pa = '{2, 4, 1}; pb = '{3, 5, 7};
        run_dot(3, 48'd10, 0, s, v);
        total++;
        if (v - s !== 7) begin bad++; $display("FAIL basic_latency: got %0d expected 7", v - s); end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busy !== 0) begin bad++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    endtask

    task automatic test_gaps();
        int s, v;
        pa = '{2, 4, 1}; pb = '{3, 5, 7};
        run_dot(3, 48'd10, 2, s, v);
        total++;
        if (v - s !== 11) begin bad++; $display("FAIL gap_latency: got %0d expected 11", v - s); end
        @(posedge clk); #1;
    endtask

    task automatic test_len0();
        int s, v;
        pa = '{}; pb = '{};
        saw_ready = 0;
        run_dot(0, 48'h0000_0000_1234, 0, s, v);
        total += 2;
        if (v - s !== 4) begin bad++; $display("FAIL len0_latency: got %0d expected 4", v - s); end
        if (saw_ready !== 0) begin bad++; $display("FAIL len0_in_ready: seen %b expected 0", saw_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int s, v;
        pa = '{3}; pb = '{3};
        out_ready = 0;
        run_dot(1, 48'd0, 0, s, v);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1 || out_data !== 48'd9) begin
                bad++;
                $display("FAIL hold_%0d: valid=%b data=%0h expected 1/9", k, out_valid, out_data);
            end
            @(posedge clk); #1;
            start = k == 1; len = 16'd2; bias = 48'd77;
        end
        out_ready = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        total++;
        if (busy !== 0) begin bad++; $display("FAIL done_start_ignored: busy=%b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int s, v;
        @(posedge clk); #1;
        start = 1; len = 16'd4; bias = 48'd100; in_valid = 1; in_a = 27'd1; in_b = 18'd1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1; in_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        total += 4;
        if (busy !== 0) begin bad++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        if (out_valid !== 0 || in_ready !== 0) begin bad++; $display("FAIL mid_rst_hs: valid=%b ready=%b expected 0/0", out_valid, in_ready); end
        if (out_data !== 48'd0) begin bad++; $display("FAIL mid_rst_data: got %0h expected 0", out_data); end
        if (dsp_a !== 27'd0 || dsp_b !== 18'd0) begin bad++; $display("FAIL mid_rst_dsp: got %0h/%0h expected 0", dsp_a, dsp_b); end
        pa = '{5}; pb = '{6};
        run_dot(1, 48'd0, 0, s, v);
        total++;
        if (v - s !== 5) begin bad++; $display("FAIL fresh_latency: got %0d expected 5", v - s); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int s, v;
        pa = '{1, 1}; pb = '{1, 1};
        run_dot(2, 48'hFFFF_FFFF_FFFF, 0, s, v);
        total++;
        if (v - s !== 6) begin bad++; $display("FAIL wrap_latency: got %0d expected 6", v - s); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len0();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL leftover: %0d results never seen, expected 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
